// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ==========================================================================
// uart_rx_fifo : UART receiver (8N1) feeding a first-word-fall-through FIFO.
// Define UART_RX_PARITY_EN for start + 8 data + even parity + stop framing.
// Revision 1.0
// ==========================================================================
module uart_rx_fifo #(
   parameter int CLKS_PER_BIT = 4167,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic                          wb_clk_i,
   input  logic                          wb_rst_i,
   input  logic                          rx_i,
   input  logic                          rd_en_i,
   input  logic                          clr_err_i,
   output logic [7:0]                    rx_data_o,
   output logic                          rx_valid_o,
   output logic                          fifo_full_o,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
   output logic                          rx_busy_o,
   output logic                          frame_err_o,
   output logic                          overrun_o,
   output logic                          parity_err_o
);

   localparam int c_cnt_w = $clog2(CLKS_PER_BIT);
   localparam int c_ptr_w = $clog2(FIFO_DEPTH);
   localparam logic [c_cnt_w-1:0] c_bit_reload  = c_cnt_w'(CLKS_PER_BIT - 1);
   localparam logic [c_cnt_w-1:0] c_half_reload = c_cnt_w'(CLKS_PER_BIT / 2 - 1);
   localparam logic [c_ptr_w:0]   c_depth       = (c_ptr_w + 1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
      S_PARITY = 3'd3,
`endif
      S_STOP   = 3'd4
   } state_e;

   logic                sync1_q, rxs_q, rxs_prev_q;
   state_e              state_q, state_d;
   logic [c_cnt_w-1:0]  cnt_q, cnt_d;
   logic [2:0]          idx_q, idx_d;
   logic [7:0]          shift_q, shift_d;
   logic                frame_err_q, overrun_q;
   logic                w_expire, w_push_req, w_frame_set;
   logic                w_pop, w_push, w_full, w_overrun_set;
   logic [7:0]          mem_q [FIFO_DEPTH];
   logic [c_ptr_w-1:0]  wr_ptr_q, rd_ptr_q;
   logic [c_ptr_w:0]    count_q;
`ifdef UART_RX_PARITY_EN
   logic                bad_q, bad_d, parity_err_q, w_parity_set;
`endif

   // Two-stage synchroniser plus one history flop for falling-edge detection
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         sync1_q    <= 1'b1;
         rxs_q      <= 1'b1;
         rxs_prev_q <= 1'b1;
      end else begin
         sync1_q    <= rx_i;
         rxs_q      <= sync1_q;
         rxs_prev_q <= rxs_q;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
`ifdef UART_RX_PARITY_EN
         bad_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
`ifdef UART_RX_PARITY_EN
         bad_q   <= bad_d;
`endif
      end
   end

   assign w_expire = (cnt_q == '0);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      shift_d     = shift_q;
      w_push_req  = 1'b0;
      w_frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
      bad_d        = bad_q;
      w_parity_set = 1'b0;
`endif
      if (state_q != S_IDLE && !w_expire) begin
         cnt_d = cnt_q - c_cnt_w'(1);
      end
      case (state_q)
         S_IDLE: begin
            if (rxs_prev_q && !rxs_q) begin
               state_d = S_START;
               cnt_d   = c_half_reload;
            end
         end
         S_START: begin
            if (w_expire) begin
               if (rxs_q) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_DATA;
                  cnt_d   = c_bit_reload;
                  idx_d   = 3'd0;
`ifdef UART_RX_PARITY_EN
                  bad_d   = 1'b0;
`endif
               end
            end
         end
         S_DATA: begin
            if (w_expire) begin
               shift_d = {rxs_q, shift_q[7:1]};
               cnt_d   = c_bit_reload;
               idx_d   = idx_q + 3'd1;
               if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (w_expire) begin
               if (rxs_q != ^shift_q) begin
                  bad_d        = 1'b1;
                  w_parity_set = 1'b1;
               end
               state_d = S_STOP;
               cnt_d   = c_bit_reload;
            end
         end
`endif
         S_STOP: begin
            if (w_expire) begin
               state_d = S_IDLE;
               if (!rxs_q) begin
                  w_frame_set = 1'b1;
`ifdef UART_RX_PARITY_EN
               end else if (!bad_q) begin
`else
               end else begin
`endif
                  w_push_req = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // A full FIFO still accepts a byte when the head is popped in the same cycle
   assign w_full        = (count_q == c_depth);
   assign w_pop         = rd_en_i && (count_q != '0);
   assign w_push        = w_push_req && (!w_full || w_pop);
   assign w_overrun_set = w_push_req && w_full && !w_pop;

   always_ff @(posedge wb_clk_i) begin
      if (w_push) begin
         mem_q[wr_ptr_q] <= shift_q;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (w_push) begin
            wr_ptr_q <= wr_ptr_q + c_ptr_w'(1);
         end
         if (w_pop) begin
            rd_ptr_q <= rd_ptr_q + c_ptr_w'(1);
         end
         if (w_push && !w_pop) begin
            count_q <= count_q + (c_ptr_w + 1)'(1);
         end else if (w_pop && !w_push) begin
            count_q <= count_q - (c_ptr_w + 1)'(1);
         end
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         frame_err_q <= (frame_err_q && !clr_err_i) || w_frame_set;
         overrun_q   <= (overrun_q && !clr_err_i) || w_overrun_set;
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         parity_err_q <= 1'b0;
      end else begin
         parity_err_q <= (parity_err_q && !clr_err_i) || w_parity_set;
      end
   end
   assign parity_err_o = parity_err_q;
`else
   assign parity_err_o = 1'b0;
`endif

   assign rx_data_o    = (count_q != '0) ? mem_q[rd_ptr_q] : 8'h00;
   assign rx_valid_o   = (count_q != '0);
   assign fifo_full_o  = w_full;
   assign fifo_count_o = count_q;
   assign rx_busy_o    = (state_q != S_IDLE);
   assign frame_err_o  = frame_err_q;
   assign overrun_o    = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ==========================================================================
// tb_uart_rx_fifo : directed + randomised bench for uart_rx_fifo with a
// queue-based reference model. Revision 1.0
// ==========================================================================
module tb_uart_rx_fifo;

   localparam int CPB   = 16;
   localparam int DEPTH = 16;
`ifdef UART_RX_PARITY_EN
   localparam int NB = 10;
`else
   localparam int NB = 9;
`endif
   // Posedge index (counted from the edge that drops rx_i) ending the stop-sample cycle's predecessor
   localparam int STOP_E = 2 + CPB / 2 + NB * CPB;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx  = 1'b1;
   logic       rd  = 1'b0;
   logic       clr = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid, fifo_full, rx_busy, frame_err, overrun, parity_err;
   logic [4:0] fifo_count;

   uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .wb_clk_i     (clk),
      .wb_rst_i     (rst),
      .rx_i         (rx),
      .rd_en_i      (rd),
      .clr_err_i    (clr),
      .rx_data_o    (rx_data),
      .rx_valid_o   (rx_valid),
      .fifo_full_o  (fifo_full),
      .fifo_count_o (fifo_count),
      .rx_busy_o    (rx_busy),
      .frame_err_o  (frame_err),
      .overrun_o    (overrun),
      .parity_err_o (parity_err)
   );

   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [7:0] q[$];
   logic       exp_frame = 1'b0;
   logic       exp_over  = 1'b0;
   logic       exp_par   = 1'b0;
`ifdef UART_RX_PARITY_EN
   logic       bad_par   = 1'b0;
`endif

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_state(input string tag);
      logic [7:0] exp_d;
      exp_d = (q.size() == 0) ? 8'h00 : q[0];
      check({tag, "_count"}, 32'(fifo_count), 32'(q.size()));
      check({tag, "_valid"}, 32'(rx_valid), 32'(q.size() != 0));
      check({tag, "_full"},  32'(fifo_full), 32'(q.size() == DEPTH));
      check({tag, "_data"},  32'(rx_data), 32'(exp_d));
      check({tag, "_ferr"},  32'(frame_err), 32'(exp_frame));
      check({tag, "_ovr"},   32'(overrun), 32'(exp_over));
      check({tag, "_perr"},  32'(parity_err), 32'(exp_par));
   endtask

   task automatic model_rx(input logic [7:0] b);
      if (q.size() < DEPTH) q.push_back(b);
      else exp_over = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_v);
      @(posedge clk); #1 rx = 1'b0;
      repeat (CPB) @(posedge clk);
      for (int k = 0; k < 8; k++) begin
         #1 rx = d[k];
         repeat (CPB) @(posedge clk);
      end
`ifdef UART_RX_PARITY_EN
      #1 rx = (^d) ^ bad_par;
      repeat (CPB) @(posedge clk);
`endif
      #1 rx = stop_v;
      repeat (CPB) @(posedge clk);
      #1 rx = 1'b1;
   endtask

   task automatic do_pop(input string tag);
      @(negedge clk);
      check({tag, "_head"}, 32'(rx_data), 32'(q[0]));
      @(posedge clk); #1 rd = 1'b1;
      @(posedge clk); #1 rd = 1'b0;
      q.delete(0);
      @(negedge clk);
      check({tag, "_cnt"}, 32'(fifo_count), 32'(q.size()));
   endtask

   task automatic pulse_clr();
      @(posedge clk); #1 clr = 1'b1;
      @(posedge clk); #1 clr = 1'b0;
      exp_frame = 1'b0;
      exp_over  = 1'b0;
      exp_par   = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] b;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_state("reset");
      check("reset_busy", 32'(rx_busy), 32'd0);

      // Single byte with exact output latency around the stop sample
      fork
         send_frame(8'h3D, 1'b1);
         begin
            repeat (STOP_E + 1) @(posedge clk);
            @(negedge clk);
            check("lat_valid_pre", 32'(rx_valid), 32'd0);
            check("lat_busy_stop", 32'(rx_busy), 32'd1);
            @(posedge clk); @(negedge clk);
            check("lat_valid", 32'(rx_valid), 32'd1);
            check("lat_data", 32'(rx_data), 32'h3D);
            check("lat_count", 32'(fifo_count), 32'd1);
            check("lat_busy_idle", 32'(rx_busy), 32'd0);
         end
      join
      model_rx(8'h3D);
      check_state("single");
      do_pop("single_pop");
      check_state("single_empty");

      // Glitch: five low cycles must abort at the mid-start sample
      fork
         begin
            @(posedge clk); #1 rx = 1'b0;
            repeat (5) @(posedge clk);
            #1 rx = 1'b1;
         end
         begin
            repeat (3) @(posedge clk); @(negedge clk);
            check("glitch_busy_t0", 32'(rx_busy), 32'd0);
            @(posedge clk); @(negedge clk);
            check("glitch_busy_t1", 32'(rx_busy), 32'd1);
            repeat (7) @(posedge clk); @(negedge clk);
            check("glitch_busy_t8", 32'(rx_busy), 32'd1);
            @(posedge clk); @(negedge clk);
            check("glitch_busy_t9", 32'(rx_busy), 32'd0);
         end
      join
      repeat (10) @(posedge clk);
      @(negedge clk);
      check_state("glitch");

      // Framing error
      send_frame(8'h0F, 1'b0);
      exp_frame = 1'b1;
      @(negedge clk);
      check_state("frame");
      pulse_clr();
      @(negedge clk);
      check_state("frame_clr");

      // Overrun: 17 bytes, no reads
      for (int i = 0; i < 17; i++) begin
         send_frame(8'(i), 1'b1);
         model_rx(8'(i));
      end
      @(negedge clk);
      check_state("overrun");
      for (int i = 0; i < DEPTH; i++) do_pop("drain");
      @(negedge clk);
      check_state("drained");
      pulse_clr();

      // Fill with random bytes, then pop exactly on the push cycle of 0xA5
      for (int i = 0; i < DEPTH; i++) begin
         b = 8'($urandom);
         send_frame(b, 1'b1);
         model_rx(b);
      end
      @(negedge clk);
      check_state("fill");
      fork
         send_frame(8'hA5, 1'b1);
         begin
            repeat (STOP_E + 1) @(posedge clk);
            #1 rd = 1'b1;
            @(posedge clk);
            #1 rd = 1'b0;
         end
      join
      q.delete(0);
      q.push_back(8'hA5);
      @(negedge clk);
      check_state("full_pop");
      for (int i = 0; i < DEPTH; i++) do_pop("drain2");
      @(negedge clk);
      check_state("drained2");

      // Random traffic with interleaved reads
      for (int i = 0; i < 12; i++) begin
         b = 8'($urandom);
         send_frame(b, 1'b1);
         model_rx(b);
         repeat ($urandom_range(0, 5)) @(posedge clk);
         @(negedge clk);
         check_state("rand");
         for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
            if (q.size() != 0) do_pop("rand_pop");
         end
      end

      // Reset during data bit 4 with the line low
      b = 8'($urandom);
      send_frame(b, 1'b1);
      model_rx(b);
      @(posedge clk); #1 rx = 1'b0;
      repeat (CPB + 4 * CPB + CPB / 2) @(posedge clk);
      @(negedge clk);
      check("midframe_busy", 32'(rx_busy), 32'd1);
      @(posedge clk); #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      rx = 1'b1;
      q.delete();
      exp_frame = 1'b0;
      exp_over  = 1'b0;
      exp_par   = 1'b0;
      @(negedge clk);
      check_state("midrst");
      check("midrst_busy", 32'(rx_busy), 32'd0);
      repeat (200) @(posedge clk);
      @(negedge clk);
      check_state("midrst_quiet");
      check("midrst_quiet_busy", 32'(rx_busy), 32'd0);
      send_frame(8'h55, 1'b1);
      model_rx(8'h55);
      @(negedge clk);
      check_state("after_rst");
      do_pop("after_rst_pop");

`ifdef UART_RX_PARITY_EN
      bad_par = 1'b0;
      send_frame(8'h0F, 1'b1);
      model_rx(8'h0F);
      @(negedge clk);
      check_state("par_good");
      bad_par = 1'b1;
      send_frame(8'h0F, 1'b1);
      exp_par = 1'b1;
      bad_par = 1'b0;
      @(negedge clk);
      check_state("par_bad");
      pulse_clr();
      @(negedge clk);
      check_state("par_clr");
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
